mem_req_arbiter: RTL and testbench

Sits between the L1 caches and the memory controller. Shares one 128-bit line-wide memory port between three requesters: icache line fill, dcache line fill and dcache writeback. Serialises them with fixed priority plus an anti-starvation override for the icache, and sequences each transaction through a one-outstanding-request FSM with a timeout watchdog.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_prio.sv | 27 ++
 rtl/mem_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the L1-to-memory request arbiter.
// The state and grant encodings are shared by the priority picker and the top level.
package mem_arb_pkg;

    localparam int ADDR_W = 26;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IC   = 2'd1,
        DR   = 2'd2,
        DW   = 2'd3
    } grant_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational grant pick: a starving icache wins outright, otherwise
// writeback > dcache refill > icache, so a victim is written before its refill.
module mem_arb_prio
    import mem_arb_pkg::*;
(
    input  logic   ic_req,
    input  logic   dr_req,
    input  logic   dw_req,
    input  logic   starve,
    output grant_e grant
);

    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = NONE;
        if (starve && ic_req) begin
            grant = IC;
        end else if (dw_req) begin
            grant = DW;
        end else if (dr_req) begin
            grant = DR;
        end else if (ic_req) begin
            grant = IC;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one line-wide memory port between icache fill, dcache fill and dcache
// writeback, one outstanding transaction at a time, with a WAIT-state watchdog.
module mem_req_arbiter #(
    parameter int ADDR_W       = mem_arb_pkg::ADDR_W,
    parameter int LINE_W       = mem_arb_pkg::LINE_W,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic              icache_ready,
    input  logic              dcache_rd_req,
    input  logic [ADDR_W-1:0] dcache_rd_addr,
    output logic              dcache_rd_ready,
    input  logic              dcache_wr_req,
    input  logic [ADDR_W-1:0] dcache_wr_addr,
    input  logic [LINE_W-1:0] dcache_wr_data,
    output logic              dcache_wr_ack,
    output logic [LINE_W-1:0] resp_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              timeout_err
);

    import mem_arb_pkg::*;

    localparam int                TCNT_W     = $clog2(TIMEOUT);
    localparam logic [TCNT_W-1:0] TMO_LAST   = TCNT_W'(TIMEOUT - 1);
    localparam logic [7:0]        STARVE_THR = 8'(STARVE_LIMIT);

    state_e            state;
    grant_e            grant;
    grant_e            pick;
    logic [7:0]        starve_cnt;
    logic              starve;
    logic [TCNT_W-1:0] tmo_cnt;
    logic              ic_granted_now;

    assign starve         = (starve_cnt >= STARVE_THR);
    assign ic_granted_now = (state == IDLE) && (pick == IC);

    mem_arb_prio u_prio (
        .ic_req (icache_req),
        .dr_req (dcache_rd_req),
        .dw_req (dcache_wr_req),
        .starve (starve),
        .grant  (pick)
    );

    // Counts cycles the icache has been kept waiting; saturates rather than wraps.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
        if (reset) begin
            starve_cnt <= '0;
        end else if (!icache_req || grant == IC || ic_granted_now) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: resp_data and the memory-side buses are plain registers, so they are cleared too.
            state           <= IDLE;
            grant           <= NONE;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            resp_data       <= '0;
            icache_ready    <= 1'b0;
            dcache_rd_ready <= 1'b0;
            dcache_wr_ack   <= 1'b0;
            tmo_cnt         <= '0;
            timeout_err     <= 1'b0;
        end else begin
            mem_req         <= 1'b0;
            icache_ready    <= 1'b0;
            dcache_rd_ready <= 1'b0;
            dcache_wr_ack   <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick != NONE) begin
                        grant   <= pick;
                        state   <= ISSUE;
                        mem_req <= 1'b1;
                        tmo_cnt <= '0;
                        case (pick)
                            DW: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= dcache_wr_addr;
                                mem_wdata <= dcache_wr_data;
                            end
                            DR: begin
                                mem_we    <= 1'b0;
                                mem_addr  <= dcache_rd_addr;
                                mem_wdata <= '0;
                            end
                            default: begin
                                mem_we    <= 1'b0;
                                mem_addr  <= icache_addr;
                                mem_wdata <= '0;
                            end
                        endcase
                    end
                end

                ISSUE: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (mem_done) begin
                        state <= RESP;
                        if (grant != DW) begin
                            resp_data <= mem_rdata;
                        end
                        case (grant)
                            IC:      icache_ready    <= 1'b1;
                            DR:      dcache_rd_ready <= 1'b1;
                            DW:      dcache_wr_ack   <= 1'b1;
                            default: ;
                        endcase
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abort quietly; the requester still holds req and is re-arbitrated.
                        timeout_err <= 1'b1;
                        grant       <= NONE;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                RESP: begin
                    grant <= NONE;
                    state <= IDLE;
                end

                default: begin
                    grant <= NONE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: latency, priority, starvation override,
// watchdog abort/retry, reset mid-transaction and stray completions.
module tb_mem_req_arbiter;

    localparam int AW = 26;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          icache_req = 1'b0;
    logic [AW-1:0] icache_addr = '0;
    logic          icache_ready;
    logic          dcache_rd_req = 1'b0;
    logic [AW-1:0] dcache_rd_addr = '0;
    logic          dcache_rd_ready;
    logic          dcache_wr_req = 1'b0;
    logic [AW-1:0] dcache_wr_addr = '0;
    logic [LW-1:0] dcache_wr_data = '0;
    logic          dcache_wr_ack;
    logic [LW-1:0] resp_data;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_done = 1'b0;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    // Memory model controls, written only by the stimulus block.
    logic          mem_auto = 1'b1;
    int            mem_lat = 1;
    logic [LW-1:0] rdata_val = '0;
    int            stray_req_cnt = 0;

    mem_req_arbiter #(
        .ADDR_W       (AW),
        .LINE_W       (LW),
        .STARVE_LIMIT (8),
        .TIMEOUT      (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .icache_req      (icache_req),
        .icache_addr     (icache_addr),
        .icache_ready    (icache_ready),
        .dcache_rd_req   (dcache_rd_req),
        .dcache_rd_addr  (dcache_rd_addr),
        .dcache_rd_ready (dcache_rd_ready),
        .dcache_wr_req   (dcache_wr_req),
        .dcache_wr_addr  (dcache_wr_addr),
        .dcache_wr_data  (dcache_wr_data),
        .dcache_wr_ack   (dcache_wr_ack),
        .resp_data       (resp_data),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_done        (mem_done),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    // Memory controller model: answers a mem_req seen in cycle t with mem_done in cycle t+mem_lat.
    int cd = 0;
    int stray_seen_cnt = 0;
    always @(negedge clk) begin
        mem_done = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                mem_done  = 1'b1;
                mem_rdata = rdata_val;
            end
        end
        if (stray_seen_cnt != stray_req_cnt) begin
            stray_seen_cnt = stray_req_cnt;
            mem_done  = 1'b1;
            mem_rdata = rdata_val;
        end
        if (mem_req && mem_auto) cd = mem_lat;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sel: 0 mem_req, 1 icache_ready, 2 dcache_rd_ready, 3 dcache_wr_ack, 4 timeout_err.
    // Returns cycles waited, or -1 when the budget runs out.
    task automatic wait_for(input int sel, input int max, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < max) begin
            tick();
            n++;
            case (sel)
                0:       seen = mem_req;
                1:       seen = icache_ready;
                2:       seen = dcache_rd_ready;
                3:       seen = dcache_wr_ack;
                default: seen = timeout_err;
            endcase
        end
        if (!seen) n = -1;
    endtask

    // Runs n idle cycles and counts any handshake or memory strobe that shows up.
    task automatic tick_quiet(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            pulses += int'(icache_ready) + int'(dcache_rd_ready) + int'(dcache_wr_ack) + int'(mem_req);
        end
    endtask

    initial begin
        int n;
        int p;
        logic [LW-1:0] line_a;
        logic [LW-1:0] line_5;
        logic [LW-1:0] line_w;
        logic [LW-1:0] line_f;
        logic [LW-1:0] line_d;
        line_a = {16{8'hAA}};
        line_5 = {16{8'h55}};
        line_w = {4{32'h12345678}};
        line_f = {16{8'h0F}};
        line_d = {4{32'hDEADBEEF}};

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_readies", {icache_ready, dcache_rd_ready, dcache_wr_ack}, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Single icache read, L=5: mem_req in cycle 1, ready in cycle 7
        mem_lat     = 5;
        rdata_val   = line_a;
        icache_addr = 26'h000_0040;
        icache_req  = 1'b1;
        wait_for(0, 20, n);
        check("ic_mem_req_cycle", n, 1);
        check("ic_mem_we", mem_we, 0);
        check("ic_mem_addr", mem_addr, 26'h40);
        wait_for(1, 20, n);
        check("ic_ready_cycle", n + 1, 7);
        check("ic_resp_data", resp_data, line_a);
        icache_req = 1'b0;
        tick();
        check("ic_ready_one_pulse", icache_ready, 0);
        tick_quiet(3, p);
        check("ic_no_reissue", p, 0);

        // Simultaneous writeback and refill to the same line: write goes first
        mem_lat        = 1;
        rdata_val      = line_5;
        dcache_wr_addr = 26'h10;
        dcache_wr_data = line_w;
        dcache_rd_addr = 26'h10;
        dcache_wr_req  = 1'b1;
        dcache_rd_req  = 1'b1;
        wait_for(0, 20, n);
        check("dw_mem_req_cycle", n, 1);
        check("dw_mem_we", mem_we, 1);
        check("dw_mem_addr", mem_addr, 26'h10);
        check("dw_mem_wdata", mem_wdata, line_w);
        wait_for(3, 20, n);
        check("dw_ack_latency", n, 2);
        check("dw_no_rd_ready", dcache_rd_ready, 0);
        check("dw_resp_unchanged", resp_data, line_a);
        dcache_wr_req = 1'b0;
        wait_for(0, 20, n);
        check("dr_mem_req_gap", n, 2);
        check("dr_mem_we", mem_we, 0);
        check("dr_mem_addr", mem_addr, 26'h10);
        wait_for(2, 20, n);
        check("dr_ready_latency", n, 2);
        check("dr_resp_data", resp_data, line_5);
        dcache_rd_req = 1'b0;
        tick_quiet(2, p);

        // Starvation: refill kept busy, icache wins the third grant in cycle 8 (mem_req cycle 9)
        rdata_val      = line_f;
        dcache_rd_addr = 26'h20;
        icache_addr    = 26'h80;
        dcache_rd_req  = 1'b1;
        icache_req     = 1'b1;
        wait_for(0, 20, n);
        check("starve_first_req", n, 1);
        check("starve_first_addr", mem_addr, 26'h20);
        wait_for(0, 20, n);
        check("starve_second_req", n, 4);
        check("starve_second_addr", mem_addr, 26'h20);
        wait_for(0, 20, n);
        check("starve_ic_req_gap", n, 4);
        check("starve_ic_addr", mem_addr, 26'h80);
        check("starve_cnt_cleared", dut.starve_cnt, 0);
        wait_for(1, 20, n);
        check("starve_ic_ready", n, 2);
        icache_req    = 1'b0;
        dcache_rd_req = 1'b0;
        tick();
        check("starve_cnt_after", dut.starve_cnt, 0);
        tick_quiet(3, p);

        // Watchdog: no mem_done, abort 64 cycles after entering WAIT, then retry
        mem_auto       = 1'b0;
        dcache_wr_addr = 26'h30;
        dcache_wr_data = line_d;
        dcache_wr_req  = 1'b1;
        wait_for(0, 20, n);
        check("tmo_first_req", n, 1);
        check("tmo_err_clear_before", timeout_err, 0);
        wait_for(4, 100, n);
        check("tmo_err_cycle", n, 65);
        mem_auto = 1'b1;
        wait_for(0, 20, n);
        check("tmo_reissue", n, 1);
        check("tmo_reissue_addr", mem_addr, 26'h30);
        check("tmo_reissue_we", mem_we, 1);
        wait_for(3, 20, n);
        check("tmo_retry_ack", n, 2);
        check("tmo_err_sticky", timeout_err, 1);
        dcache_wr_req = 1'b0;
        tick_quiet(2, p);

        // Reset during WAIT, then a late mem_done
        mem_auto    = 1'b0;
        icache_addr = 26'h44;
        icache_req  = 1'b1;
        wait_for(0, 20, n);
        check("rstw_mem_req", n, 1);
        tick();
        tick();
        reset      = 1'b1;
        icache_req = 1'b0;
        tick();
        reset = 1'b0;
        check("rstw_mem_addr", mem_addr, 0);
        check("rstw_resp_data", resp_data, 0);
        check("rstw_timeout_err", timeout_err, 0);
        check("rstw_mem_we", mem_we, 0);
        rdata_val = line_d;
        stray_req_cnt++;
        tick_quiet(4, p);
        check("rstw_stray_no_pulse", p, 0);
        check("rstw_stray_resp", resp_data, 0);

        // mem_done while idle leaves every output alone
        mem_auto    = 1'b1;
        mem_lat     = 2;
        rdata_val   = line_f;
        icache_addr = 26'h50;
        icache_req  = 1'b1;
        wait_for(1, 20, n);
        check("idle_setup_ready", n, 4);
        icache_req = 1'b0;
        tick_quiet(2, p);
        rdata_val = line_d;
        stray_req_cnt++;
        tick_quiet(4, p);
        check("idle_stray_no_pulse", p, 0);
        check("idle_stray_resp", resp_data, line_f);
        check("idle_stray_addr", mem_addr, 26'h50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
